icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
Miss handler and fill writer for the ICache. It sits on the other side of the tag/data arrays from the fetch2 match stage. When fetch reports a miss it accepts the physical address, issues one line-aligned read to memory and collects the line beat by beat. It then writes one tag entry and one data entry into a way chosen by round-robin.

Parameters:
ASSOC, `ICACHE_ASSOC, number of ways; legal range is 2 to 8, power of two.
LINE_BEATS, 4, memory beats per cache line; power of two.
BEAT_WIDTH, 64, bits per memory beat; line is LINE_BEATS*BEAT_WIDTH bits and equals $bits of the icache_data_entry_t data field.
INDEX_WIDTH, 6, set index bits.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  abort refill, suppress write
i_miss_valid  in  1  fetch reports ICache miss
i_miss_paddr  in  $bits(paddr_t)  missing physical address
o_miss_ready  out  1  idle, able to accept a miss
o_mem_req_valid  out  1  line read request
o_mem_req_addr  out  $bits(paddr_t)  line-aligned address, offset bits zero
i_mem_req_ready  in  1  memory accepts request
i_mem_resp_valid  in  1  one beat valid
i_mem_resp_data  in  BEAT_WIDTH  beat payload
i_mem_resp_err  in  1  bus error on this beat
o_fill_valid  out  1  one-cycle array write strobe
o_fill_way  out  $clog2(ASSOC)  way to write
o_fill_index  out  INDEX_WIDTH  set to write
o_fill_tag  out  icache_tag_entry_t  compose_icache_tag_entry(latched paddr)
o_fill_data  out  icache_data_entry_t  assembled line
o_fill_err  out  1  one-cycle pulse: refill ended with bus error, nothing written
o_busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, beat counter 0, round-robin way 0, error flag 0, line buffer 0. All outputs are 0 except o_miss_ready=1.
- OFFSET_WIDTH = $clog2(LINE_BEATS*BEAT_WIDTH/8), which is 5 by default.
- o_fill_index = paddr[OFFSET_WIDTH +: INDEX_WIDTH].
- State IDLE:
  - o_miss_ready=1.
  - On i_miss_valid, latch paddr and go to REQ.
  - i_flush in IDLE has no effect.
- State REQ:
  - o_mem_req_valid=1; o_mem_req_addr is held stable.
  - On i_mem_req_ready, go to RECV with beat counter 0.
  - i_flush (priority over ready) returns to IDLE; no request is counted as issued.
- State RECV:
  - Each i_mem_resp_valid writes beat k into line bits [k*BEAT_WIDTH +: BEAT_WIDTH], in order from the line base.
  - i_mem_resp_err ORs into a sticky error flag.
  - The beat counter increments on each beat.
  - On beat LINE_BEATS-1, go to WRITE if no error, otherwise go to ERR.
- State WRITE (1 cycle):
  - o_fill_valid = ~i_flush, with way, index, tag and data driven from registers.
  - If written, the round-robin way advances, wrapping ASSOC-1 to 0.
  - Next state is IDLE.
- State ERR (1 cycle): o_fill_err=1; round-robin is not advanced; next state is IDLE.
- State DRAIN:
  - Entered when i_flush occurs in RECV.
  - The block keeps counting response beats; a flush beat arriving that same cycle is counted.
  - Line data is discarded; after the last beat it goes to IDLE.
  - No o_fill_valid and no o_fill_err are produced.
  - Further i_flush while in DRAIN has no effect.
- Responses in IDLE/REQ are ignored. Memory guarantees the first beat arrives at least 1 cycle after the request handshake.
- Latency:
  - Miss accepted in cycle N: o_mem_req_valid in N+1.
  - If ready in N+1, beats are accepted from N+2.
  - Last beat in cycle M: o_fill_valid in M+1, o_miss_ready back in M+2.
  - Best-case miss-to-write is LINE_BEATS+2 cycles.
- Asynchronous reset mid-refill returns to IDLE immediately. Outstanding memory beats after reset are the memory side's responsibility.

Decomposition:
- Shared package (caches.svh) gets:
  - ICACHE_LINE_BEATS and ICACHE_BEAT_WIDTH constants.
  - ICACHE_OFFSET_WIDTH and ICACHE_INDEX_WIDTH constants.
  - the icache_refill_state_t enum (IDLE, REQ, RECV, WRITE, ERR, DRAIN).
- compose_icache_tag_entry is reused.
- One sub-module, rr_way_select: a round-robin way counter with an advance input and a way output.

Test Plan:
- Basic miss:
  - Stimulus: miss paddr 0x0000_1234, req_ready immediate, 4 beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles.
  - Response: req_addr 0x0000_1220, index 0x11, way 0, data beats placed low to high, o_fill_valid exactly 1 cycle, o_miss_ready after.
- Round-robin:
  - Stimulus: ASSOC+1 back-to-back misses.
  - Response: ways 0,1,..,ASSOC-1,0.
- Backpressure and gaps:
  - Stimulus: req_ready low for 5 cycles; beats with 2-cycle gaps.
  - Response: o_mem_req_addr stable; write occurs 1 cycle after the 4th beat.
- Bus error:
  - Stimulus: err on beat 2.
  - Response: all 4 beats consumed, o_fill_err 1 cycle, no o_fill_valid, next refill still uses the same way.
- Flush cases (each with no write and a clean return to IDLE):
  - Flush in REQ: IDLE next cycle.
  - Flush after beat 1: DRAIN absorbs beats 2–4, then IDLE.
  - Flush in WRITE: o_fill_valid stays 0.
- Reset:
  - Stimulus: i_rst_n low during RECV.
  - Response: o_busy=0 and o_miss_ready=1 immediately; round-robin way is 0.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared ICache refill types: address/tag/data entry layouts, refill FSM states
// and the tag composition helper used by both the match stage and the fill writer.
package icache_refill_pkg;

  localparam int ICACHE_ASSOC        = 4;
  localparam int ICACHE_LINE_BEATS   = 4;
  localparam int ICACHE_BEAT_WIDTH   = 64;
  localparam int ICACHE_INDEX_WIDTH  = 6;
  localparam int PADDR_WIDTH         = 32;
  localparam int ICACHE_LINE_WIDTH   = ICACHE_LINE_BEATS * ICACHE_BEAT_WIDTH;
  localparam int ICACHE_OFFSET_WIDTH = $clog2(ICACHE_LINE_WIDTH / 8);
  localparam int ICACHE_TAG_WIDTH    = PADDR_WIDTH - ICACHE_OFFSET_WIDTH - ICACHE_INDEX_WIDTH;

  typedef logic [PADDR_WIDTH-1:0] paddr_t;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_WIDTH-1:0] tag;
  } icache_tag_entry_t;

  typedef struct packed {
    logic [ICACHE_LINE_WIDTH-1:0] data;
  } icache_data_entry_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RECV  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4,
    DRAIN = 3'd5
  } icache_refill_state_t;

  function automatic icache_tag_entry_t compose_icache_tag_entry(input paddr_t paddr);
    icache_tag_entry_t e;
    e.valid = 1'b1;
    e.tag   = paddr[PADDR_WIDTH-1 -: ICACHE_TAG_WIDTH];
    return e;
  endfunction

endpackage

// File: rtl/icache_refill_rr_way_select.sv
// Round-robin victim way counter; advances only on a committed fill.
module rr_way_select #(
  parameter int ASSOC = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_advance,
  output logic [$clog2(ASSOC)-1:0] o_way
);

  localparam int WW = $clog2(ASSOC);

  logic [WW-1:0] way_q, way_d;

  always_comb begin
    way_d = way_q;
    if (i_advance) begin
      way_d = (way_q == WW'(ASSOC - 1)) ? '0 : way_q + WW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) way_q <= '0;
    else          way_q <= way_d;
  end

  assign o_way = way_q;

endmodule

// File: rtl/icache_refill.sv
// ICache miss handler: issues one line read, assembles the returned beats and
// writes one tag + data entry into a round-robin way, or reports a bus error.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ASSOC       = ICACHE_ASSOC,
  parameter int LINE_BEATS  = ICACHE_LINE_BEATS,
  parameter int BEAT_WIDTH  = ICACHE_BEAT_WIDTH,
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_miss_valid,
  input  paddr_t                   i_miss_paddr,
  output logic                     o_miss_ready,
  output logic                     o_mem_req_valid,
  output paddr_t                   o_mem_req_addr,
  input  logic                     i_mem_req_ready,
  input  logic                     i_mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0]    i_mem_resp_data,
  input  logic                     i_mem_resp_err,
  output logic                     o_fill_valid,
  output logic [$clog2(ASSOC)-1:0] o_fill_way,
  output logic [INDEX_WIDTH-1:0]   o_fill_index,
  output icache_tag_entry_t        o_fill_tag,
  output icache_data_entry_t       o_fill_data,
  output logic                     o_fill_err,
  output logic                     o_busy
);

  localparam int LINE_WIDTH   = LINE_BEATS * BEAT_WIDTH;
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
  localparam int LADDR_WIDTH  = PADDR_WIDTH - OFFSET_WIDTH;
  localparam int BCW          = $clog2(LINE_BEATS);

  // Handshakes: miss and mem request transfer on a cycle where valid and ready
  // are both high; valid, once raised, holds with a stable payload until then.
  // Response beats have no ready and are taken on every cycle valid is high.

  icache_refill_state_t   state_q, state_d;
  logic [LADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [BCW-1:0]         beat_q, beat_d;
  logic                   err_q, err_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic                   rr_advance;
  logic [$clog2(ASSOC)-1:0] rr_way;
  logic                   last_beat;
  logic                   in_write;
  logic                   unused_offset_bits;

  assign last_beat          = (beat_q == BCW'(LINE_BEATS - 1));
  assign unused_offset_bits = ^i_miss_paddr[OFFSET_WIDTH-1:0];

  always_comb begin
    state_d         = state_q;
    line_addr_d     = line_addr_q;
    beat_d          = beat_q;
    err_d           = err_q;
    line_d          = line_q;
    rr_advance      = 1'b0;
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_fill_valid    = 1'b0;
    o_fill_err      = 1'b0;
    case (state_q)
      IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss_valid) begin
          line_addr_d = i_miss_paddr[PADDR_WIDTH-1:OFFSET_WIDTH];
          err_d       = 1'b0;
          beat_d      = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_flush) begin
          state_d = IDLE;
        end else if (i_mem_req_ready) begin
          beat_d  = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (i_mem_resp_valid) begin
          beat_d = beat_q + BCW'(1);
          if (i_flush) begin
            // The flushed beat still counts, so a flush on the last beat has nothing left to drain.
            state_d = last_beat ? IDLE : DRAIN;
          end else begin
            line_d[int'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH] = i_mem_resp_data;
            err_d = err_q | i_mem_resp_err;
            if (last_beat) state_d = (err_q | i_mem_resp_err) ? ERR : WRITE;
          end
        end else if (i_flush) begin
          state_d = DRAIN;
        end
      end
      WRITE: begin
        o_fill_valid = ~i_flush;
        rr_advance   = ~i_flush;
        state_d      = IDLE;
      end
      ERR: begin
        o_fill_err = 1'b1;
        state_d    = IDLE;
      end
      DRAIN: begin
        if (i_mem_resp_valid) begin
          beat_d = beat_q + BCW'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      line_q      <= line_d;
    end
  end

  rr_way_select #(.ASSOC(ASSOC)) u_rr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_advance (rr_advance),
    .o_way     (rr_way)
  );

  // Fill payload is held at zero outside WRITE so the array bus idles quietly.
  assign in_write       = (state_q == WRITE);
  assign o_mem_req_addr = paddr_t'({line_addr_q, {OFFSET_WIDTH{1'b0}}});
  assign o_fill_way     = in_write ? rr_way : '0;
  assign o_fill_index   = in_write ? line_addr_q[INDEX_WIDTH-1:0] : '0;
  assign o_fill_tag     = in_write ? compose_icache_tag_entry(o_mem_req_addr) : '0;
  assign o_fill_data    = in_write ? icache_data_entry_t'(line_q) : '0;
  assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: basic fill, round-robin, backpressure,
// bus error, the three flush points and asynchronous reset mid-refill.
module tb_icache_refill;
  import icache_refill_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               miss_valid;
  paddr_t             miss_paddr;
  logic               miss_ready;
  logic               req_valid;
  paddr_t             req_addr;
  logic               req_ready;
  logic               resp_valid;
  logic [63:0]        resp_data;
  logic               resp_err;
  logic               fill_valid;
  logic [1:0]         fill_way;
  logic [5:0]         fill_index;
  icache_tag_entry_t  fill_tag;
  icache_data_entry_t fill_data;
  logic               fill_err;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  int           mon_fill_cnt, mon_err_cnt, mon_pre_cnt, mon_fill_lat, mon_err_lat;
  bit           mon_addr_ok;
  logic [1:0]   mon_way;
  logic [5:0]   mon_index;
  logic [21:0]  mon_tag;
  logic [255:0] mon_data;

  icache_refill #(.ASSOC(4)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_flush          (flush),
    .i_miss_valid     (miss_valid),
    .i_miss_paddr     (miss_paddr),
    .o_miss_ready     (miss_ready),
    .o_mem_req_valid  (req_valid),
    .o_mem_req_addr   (req_addr),
    .i_mem_req_ready  (req_ready),
    .i_mem_resp_valid (resp_valid),
    .i_mem_resp_data  (resp_data),
    .i_mem_resp_err   (resp_err),
    .o_fill_valid     (fill_valid),
    .o_fill_way       (fill_way),
    .o_fill_index     (fill_index),
    .o_fill_tag       (fill_tag),
    .o_fill_data      (fill_data),
    .o_fill_err       (fill_err),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, outputs are read at posedge+3.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [63:0] beat_val(input int k, input logic [7:0] salt);
    logic [7:0] b;
    b = 8'((k + 1) * 17) ^ salt;
    return {8{b}};
  endfunction

  task automatic sample(input int win);
    if (fill_valid === 1'b1) begin
      mon_fill_cnt++;
      mon_way   = fill_way;
      mon_index = fill_index;
      mon_tag   = fill_tag;
      mon_data  = fill_data;
      if (win < 0) mon_pre_cnt++;
      else         mon_fill_lat = win;
    end
    if (fill_err === 1'b1) begin
      mon_err_cnt++;
      if (win < 0) mon_pre_cnt++;
      else         mon_err_lat = win;
    end
  endtask

  // Drives one whole refill; the window sample is the cycle right after the last beat.
  task automatic run_refill(input logic [31:0] pa, input int req_delay, input int gap,
                            input int err_beat, input bit flush_write, input logic [7:0] salt);
    mon_fill_cnt = 0; mon_err_cnt = 0; mon_pre_cnt = 0;
    mon_fill_lat = -1; mon_err_lat = -1; mon_addr_ok = 1'b1;
    miss_valid = 1'b1; miss_paddr = pa;
    settle(); sample(-1); adv();
    miss_valid = 1'b0; miss_paddr = 32'hDEAD_BEEF;
    for (int i = 0; i <= req_delay; i++) begin
      req_ready = (i == req_delay);
      settle();
      if (!(req_valid === 1'b1 && req_addr === {pa[31:5], 5'b0})) mon_addr_ok = 1'b0;
      sample(-1); adv();
    end
    req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      resp_valid = 1'b1; resp_data = beat_val(k, salt); resp_err = (k == err_beat);
      settle(); sample(-1); adv();
      resp_valid = 1'b0; resp_data = '0; resp_err = 1'b0;
      if (k < 3) begin
        for (int g = 0; g < gap; g++) begin
          settle(); sample(-1); adv();
        end
      end
    end
    flush = flush_write;
    settle(); sample(0); adv();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; miss_valid = 1'b0; miss_paddr = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_err = 1'b0;
    #2;
    checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL reset_miss_ready got=%b exp=1", miss_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
    checks++; if (req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", req_addr); end
    checks++; if (fill_valid !== 1'b0 || fill_err !== 1'b0) begin failures++; $display("FAIL reset_fill_strobes got=%b%b exp=00", fill_valid, fill_err); end
    checks++; if (fill_way !== 2'd0 || fill_index !== 6'd0) begin failures++; $display("FAIL reset_way_index got=%0d/%0d exp=0/0", fill_way, fill_index); end
    checks++; if (fill_tag !== 22'h0 || fill_data !== 256'h0) begin failures++; $display("FAIL reset_tag_data got=%h/%h exp=0", fill_tag, fill_data); end
    adv(); adv();
    rst_n = 1'b1;
    adv();
  endtask

  task automatic test_basic_miss();
    run_refill(32'h0000_1234, 0, 0, -1, 1'b0, 8'h00);
    checks++; if (mon_addr_ok !== 1'b1) begin failures++; $display("FAIL basic_req_addr got=%h exp=00001220", req_addr); end
    checks++; if (mon_fill_cnt !== 1 || mon_pre_cnt !== 0) begin failures++; $display("FAIL basic_fill_count got=%0d early=%0d exp=1/0", mon_fill_cnt, mon_pre_cnt); end
    checks++; if (mon_fill_lat !== 0) begin failures++; $display("FAIL basic_fill_latency got=%0d exp=0", mon_fill_lat); end
    checks++; if (mon_way !== 2'd0) begin failures++; $display("FAIL basic_way got=%0d exp=0", mon_way); end
    checks++; if (mon_index !== 6'h11) begin failures++; $display("FAIL basic_index got=%h exp=11", mon_index); end
    checks++; if (mon_tag !== {1'b1, 21'h2}) begin failures++; $display("FAIL basic_tag got=%h exp=%h", mon_tag, {1'b1, 21'h2}); end
    checks++; if (mon_data !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
      failures++; $display("FAIL basic_data got=%h", mon_data); end
    settle();
    checks++; if (miss_ready !== 1'b1 || busy !== 1'b0 || fill_valid !== 1'b0) begin
      failures++; $display("FAIL basic_return_idle got ready=%b busy=%b fill=%b exp=1/0/0", miss_ready, busy, fill_valid); end
    adv();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; #2; rst_n = 1'b1; adv();
    for (int i = 0; i < 5; i++) begin
      run_refill(32'h0000_4000 + 32'(i * 32), 0, 0, -1, 1'b0, 8'(i));
      checks++; if (mon_fill_cnt !== 1 || mon_pre_cnt !== 0) begin failures++; $display("FAIL rr_fill_count[%0d] got=%0d early=%0d exp=1/0", i, mon_fill_cnt, mon_pre_cnt); end
      checks++; if (mon_way !== 2'(i % 4)) begin failures++; $display("FAIL rr_way[%0d] got=%0d exp=%0d", i, mon_way, i % 4); end
      checks++; if (mon_index !== 6'(i)) begin failures++; $display("FAIL rr_index[%0d] got=%0d exp=%0d", i, mon_index, i); end
    end
  endtask

  task automatic test_backpressure();
    run_refill(32'h0000_ABCD, 5, 2, -1, 1'b0, 8'h5A);
    checks++; if (mon_addr_ok !== 1'b1) begin failures++; $display("FAIL bp_req_addr_stable got=%h exp=0000abc0", req_addr); end
    checks++; if (mon_fill_cnt !== 1 || mon_pre_cnt !== 0 || mon_fill_lat !== 0) begin
      failures++; $display("FAIL bp_fill_timing got cnt=%0d early=%0d lat=%0d exp=1/0/0", mon_fill_cnt, mon_pre_cnt, mon_fill_lat); end
    checks++; if (mon_way !== 2'd1) begin failures++; $display("FAIL bp_way got=%0d exp=1", mon_way); end
    checks++; if (mon_index !== 6'h1E || mon_tag !== {1'b1, 21'h15}) begin failures++; $display("FAIL bp_index_tag got=%h/%h exp=1e/%h", mon_index, mon_tag, {1'b1, 21'h15}); end
    checks++; if (mon_data !== {beat_val(3, 8'h5A), beat_val(2, 8'h5A), beat_val(1, 8'h5A), beat_val(0, 8'h5A)}) begin
      failures++; $display("FAIL bp_data got=%h", mon_data); end
  endtask

  task automatic test_bus_error();
    run_refill(32'h0000_2000, 0, 0, 2, 1'b0, 8'h33);
    checks++; if (mon_err_cnt !== 1 || mon_err_lat !== 0 || mon_pre_cnt !== 0) begin
      failures++; $display("FAIL err_pulse got cnt=%0d lat=%0d early=%0d exp=1/0/0", mon_err_cnt, mon_err_lat, mon_pre_cnt); end
    checks++; if (mon_fill_cnt !== 0) begin failures++; $display("FAIL err_no_fill got=%0d exp=0", mon_fill_cnt); end
    run_refill(32'h0000_2040, 0, 0, -1, 1'b0, 8'h44);
    checks++; if (mon_fill_cnt !== 1 || mon_err_cnt !== 0 || mon_pre_cnt !== 0) begin
      failures++; $display("FAIL err_next_fill got cnt=%0d err=%0d early=%0d exp=1/0/0", mon_fill_cnt, mon_err_cnt, mon_pre_cnt); end
    checks++; if (mon_way !== 2'd2) begin failures++; $display("FAIL err_way_held got=%0d exp=2", mon_way); end
  endtask

  task automatic test_flush_req();
    miss_valid = 1'b1; miss_paddr = 32'h0000_3000;
    adv();
    miss_valid = 1'b0; flush = 1'b1; req_ready = 1'b1;
    settle();
    checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL flush_req_in_req got=%b exp=1", req_valid); end
    adv();
    flush = 1'b0; req_ready = 1'b0;
    settle();
    checks++; if (busy !== 1'b0 || miss_ready !== 1'b1 || req_valid !== 1'b0) begin
      failures++; $display("FAIL flush_req_idle got busy=%b ready=%b req=%b exp=0/1/0", busy, miss_ready, req_valid); end
    adv();
  endtask

  task automatic test_flush_drain();
    int bad;
    bad = 0;
    miss_valid = 1'b1; miss_paddr = 32'h0000_3100;
    adv();
    miss_valid = 1'b0; req_ready = 1'b1;
    adv();
    req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      resp_valid = 1'b1; resp_data = beat_val(k, 8'h77); flush = (k == 1 || k == 2);
      settle();
      if (fill_valid !== 1'b0 || fill_err !== 1'b0) bad++;
      if (k >= 2 && busy !== 1'b1) bad++;
      adv();
    end
    resp_valid = 1'b0; flush = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL drain_during_beats got=%0d errors exp=0", bad); end
    settle();
    checks++; if (busy !== 1'b0 || miss_ready !== 1'b1) begin failures++; $display("FAIL drain_idle got busy=%b ready=%b exp=0/1", busy, miss_ready); end
    adv(); settle();
    checks++; if (fill_valid !== 1'b0 || fill_err !== 1'b0) begin failures++; $display("FAIL drain_no_pulse got=%b%b exp=00", fill_valid, fill_err); end
    adv();
  endtask

  task automatic test_flush_write();
    run_refill(32'h0000_6000, 0, 0, -1, 1'b1, 8'h21);
    checks++; if (mon_fill_cnt !== 0 || mon_err_cnt !== 0) begin failures++; $display("FAIL flush_write_no_fill got fill=%0d err=%0d exp=0/0", mon_fill_cnt, mon_err_cnt); end
    settle();
    checks++; if (busy !== 1'b0 || miss_ready !== 1'b1) begin failures++; $display("FAIL flush_write_idle got busy=%b ready=%b exp=0/1", busy, miss_ready); end
    adv();
    run_refill(32'h0000_6020, 0, 0, -1, 1'b0, 8'h22);
    checks++; if (mon_fill_cnt !== 1 || mon_pre_cnt !== 0 || mon_way !== 2'd3) begin
      failures++; $display("FAIL flush_write_way_held got cnt=%0d early=%0d way=%0d exp=1/0/3", mon_fill_cnt, mon_pre_cnt, mon_way); end
  endtask

  task automatic test_reset_mid();
    run_refill(32'h0000_7000, 0, 0, -1, 1'b0, 8'h10);
    checks++; if (mon_way !== 2'd0) begin failures++; $display("FAIL rst_pre_way got=%0d exp=0", mon_way); end
    miss_valid = 1'b1; miss_paddr = 32'h0000_7020;
    adv();
    miss_valid = 1'b0; req_ready = 1'b1;
    adv();
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = beat_val(0, 8'h10);
    adv();
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || miss_ready !== 1'b1 || req_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle got busy=%b ready=%b req=%b exp=0/1/0", busy, miss_ready, req_valid); end
    resp_valid = 1'b0;
    adv();
    rst_n = 1'b1;
    adv();
    run_refill(32'h0000_7040, 0, 0, -1, 1'b0, 8'h11);
    checks++; if (mon_fill_cnt !== 1 || mon_way !== 2'd0) begin failures++; $display("FAIL rst_way_cleared got cnt=%0d way=%0d exp=1/0", mon_fill_cnt, mon_way); end
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_round_robin();
    test_backpressure();
    test_bus_error();
    test_flush_req();
    test_flush_drain();
    test_flush_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
